// File: rtl/alu32.sv
// alu32: combinational 32-bit integer ALU with a registered {Z,N,C,V}
// status-flag stage sampled on every rising clock edge.
module alu32 (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  op,
   output logic [31:0] result,
   output logic        carry_out,
   output logic        flag_z,
   output logic        flag_n,
   output logic        flag_c,
   output logic        flag_v
);

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_AND  = 4'b0010;
   localparam logic [3:0] OP_OR   = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_NOT  = 4'b0101;
   localparam logic [3:0] OP_SLL  = 4'b0110;
   localparam logic [3:0] OP_SRL  = 4'b0111;
   localparam logic [3:0] OP_SRA  = 4'b1000;
   localparam logic [3:0] OP_SLT  = 4'b1001;
   localparam logic [3:0] OP_SLTU = 4'b1010;
   localparam logic [3:0] OP_NOR  = 4'b1011;
   localparam logic [3:0] OP_XNOR = 4'b1100;
   localparam logic [3:0] OP_PASS = 4'b1101;
   localparam logic [3:0] OP_ROL  = 4'b1110;
   localparam logic [3:0] OP_ROR  = 4'b1111;

   logic [4:0]  shamt;
   logic [5:0]  rot_back;
   logic [32:0] add33;
   logic [32:0] sub33;
   logic [32:0] sll33;   // bit 32 holds the last bit shifted out
   logic [32:0] srl33;   // bit 0 holds the last bit shifted out
   logic [32:0] sra33;
   logic [31:0] rol32;
   logic [31:0] ror32;
   logic        slt;
   logic        ovf;

   assign shamt    = b[4:0];
   // For shamt = 0 this is 32, which shifts everything out and leaves a
   // plain rotate-by-zero.
   assign rot_back = 6'd32 - {1'b0, shamt};

   // Shared datapath terms for all opcodes
   always_comb begin
      add33 = {1'b0, a} + {1'b0, b};
      sub33 = {1'b0, a} - {1'b0, b};
      sll33 = {1'b0, a} << shamt;
      srl33 = {a, 1'b0} >> shamt;
      sra33 = $signed({a, 1'b0}) >>> shamt;
      rol32 = (a << shamt) | (a >> rot_back);
      ror32 = (a >> shamt) | (a << rot_back);
      slt   = (a[31] != b[31]) ? a[31] : sub33[31];
   end

   // Opcode decode: result and carry/borrow/shift-out
   always_comb begin
      result    = 32'd0;
      carry_out = 1'b0;
      case (op)
         OP_ADD:  begin result = add33[31:0]; carry_out = add33[32]; end
         OP_SUB:  begin result = sub33[31:0]; carry_out = sub33[32]; end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NOT:  result = ~a;
         OP_SLL:  begin result = sll33[31:0]; carry_out = sll33[32]; end
         OP_SRL:  begin result = srl33[32:1]; carry_out = srl33[0]; end
         OP_SRA:  begin result = sra33[32:1]; carry_out = sra33[0]; end
         OP_SLT:  result = {31'd0, slt};
         OP_SLTU: result = {31'd0, sub33[32]};
         OP_NOR:  result = ~(a | b);
         OP_XNOR: result = ~(a ^ b);
         OP_PASS: result = b;
         OP_ROL:  result = rol32;
         OP_ROR:  result = ror32;
         default: result = 32'd0;
      endcase
   end

   // Signed overflow, meaningful only for ADD/SUB
   always_comb begin
      ovf = 1'b0;
      if (op == OP_ADD)
         ovf = (a[31] == b[31]) && (add33[31] != a[31]);
      else if (op == OP_SUB)
         ovf = (a[31] != b[31]) && (sub33[31] != a[31]);
   end

   // Flag register: loads every cycle, cleared asynchronously by rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flag_z <= 1'b0;
         flag_n <= 1'b0;
         flag_c <= 1'b0;
         flag_v <= 1'b0;
      end else begin
         flag_z <= (result == 32'd0);
         flag_n <= result[31];
         flag_c <= carry_out;
         flag_v <= ovf;
      end
   end

endmodule

// File: tb/tb_alu32.sv
// tb_alu32: directed + random checks of alu32 against an arithmetic model.
module tb_alu32;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic [3:0]  op = 4'd0;
   logic [31:0] result;
   logic        carry_out;
   logic        flag_z, flag_n, flag_c, flag_v;

   int total = 0;
   int bad   = 0;

   alu32 dut (
      .clk(clk), .rst(rst), .a(a), .b(b), .op(op),
      .result(result), .carry_out(carry_out),
      .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v)
   );

   always #5 clk = ~clk;

   // Reference model written straight from the opcode table.
   task automatic model(input logic [3:0] mop, input logic [31:0] ma,
                        input logic [31:0] mb, output logic [31:0] r,
                        output logic c, output logic v);
      longint unsigned ua, ub, wide;
      longint          sa, sb, sw;
      int              s;
      int              sia;
      ua = {32'd0, ma};
      ub = {32'd0, mb};
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      s  = int'(mb[4:0]);
      sia = $signed(ma);
      r = 32'd0; c = 1'b0; v = 1'b0;
      case (mop)
         4'd0: begin
            wide = ua + ub; r = wide[31:0]; c = wide[32];
            sw = sa + sb; v = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
         end
         4'd1: begin
            wide = ua - ub; r = wide[31:0]; c = (ua < ub);
            sw = sa - sb; v = (sw > 64'sd2147483647) || (sw < -64'sd2147483648);
         end
         4'd2:  r = ma & mb;
         4'd3:  r = ma | mb;
         4'd4:  r = ma ^ mb;
         4'd5:  r = ~ma;
         4'd6: begin
            r = ma << s;
            if (s != 0) c = ma[32 - s];
         end
         4'd7: begin
            r = ma >> s;
            if (s != 0) c = ma[s - 1];
         end
         4'd8: begin
            r = sia >>> s;
            if (s != 0) c = ma[s - 1];
         end
         4'd9:  r = (sa < sb) ? 32'd1 : 32'd0;
         4'd10: r = (ua < ub) ? 32'd1 : 32'd0;
         4'd11: r = ~(ma | mb);
         4'd12: r = ~(ma ^ mb);
         4'd13: r = mb;
         4'd14: r = (s == 0) ? ma : ((ma << s) | (ma >> (32 - s)));
         default: r = (s == 0) ? ma : ((ma >> s) | (ma << (32 - s)));
      endcase
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive one op mid-cycle, check combinational outputs, then flags after the edge.
   task automatic step(input string tag, input logic [3:0] sop,
                       input logic [31:0] sa, input logic [31:0] sb);
      logic [31:0] er;
      logic        ec, ev;
      op = sop; a = sa; b = sb;
      #2;
      model(sop, sa, sb, er, ec, ev);
      check({tag, ".result"}, result, er);
      check({tag, ".carry"}, {31'd0, carry_out}, {31'd0, ec});
      @(posedge clk); #1;
      check({tag, ".flags"}, {28'd0, flag_z, flag_n, flag_c, flag_v},
            {28'd0, (er == 32'd0), er[31], ec, ev});
   endtask

   initial begin
      // Reset state
      #12;
      check("reset.flags", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // ADD
      step("add0", 4'd0, 32'h12345678, 32'h87654321);
      check("add0.lit", result, 32'h99999999);
      for (int j = 0; j < 10; j++)
         step($sformatf("addsweep%0d", j), 4'd0, 32'h12345678 + j, 32'h87654321 - j);
      step("add_wrap", 4'd0, 32'hFFFFFFFF, 32'h00000001);
      check("add_wrap.lit", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'b1010);

      // Async reset mid-cycle while flag_z=1, inputs still give result 0
      #2 rst = 1'b1;
      #1;
      check("rst.immediate", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'd0);
      check("rst.result", {carry_out, result[30:0]}, 32'h80000000);
      @(posedge clk); #1;
      check("rst.hold", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'd0);
      #2 rst = 1'b0;
      @(posedge clk); #1;
      check("rst.reload", {28'd0, flag_z, flag_n, flag_c, flag_v}, 32'b1010);

      // SUB
      step("sub0", 4'd1, 32'hABCDEF00, 32'h12345678);
      check("sub0.lit", result, 32'h99999888);
      step("sub_eq", 4'd1, 32'h80000000, 32'h80000000);
      check("sub_eq.lit", result, 32'd0);
      step("sub_ovf", 4'd1, 32'h7FFFFFFF, 32'hFFFFFFFF);
      check("sub_ovf.v", {31'd0, flag_v}, 32'd1);
      step("sub_borrow", 4'd1, 32'h00000001, 32'h00000002);

      // Logic
      step("and", 4'd2, 32'hF0F0F0F0, 32'h0F0F0F0F);
      check("and.lit", result, 32'd0);
      step("or", 4'd3, 32'hF0F0F0F0, 32'h0F0F0F0F);
      check("or.lit", result, 32'hFFFFFFFF);
      step("xor", 4'd4, 32'hF0F0F0F0, 32'h0F0F0F0F);
      check("xor.lit", result, 32'hFFFFFFFF);
      step("not", 4'd5, 32'hF0F0F0F0, 32'h0F0F0F0F);
      check("not.lit", result, 32'h0F0F0F0F);

      // Shifts
      step("sll4", 4'd6, 32'h12345678, 32'd4);
      check("sll4.lit", result, 32'h23456780);
      step("srl4", 4'd7, 32'h12345678, 32'd4);
      check("srl4.lit", result, 32'h01234567);
      step("sll1", 4'd6, 32'h12345678, 32'd1);
      check("sll1.lit", result, 32'h2468ACF0);
      step("srl1", 4'd7, 32'h12345678, 32'd1);
      check("srl1.lit", result, 32'h091A2B3C);
      step("sll0", 4'd6, 32'h12345678, 32'd0);
      check("sll0.lit", {carry_out, result[30:0]}, 32'h12345678);
      step("sll31", 4'd6, 32'h00000003, 32'd31);
      step("sra31", 4'd8, 32'h80000001, 32'hFFFFFFFF);
      step("ror1", 4'd15, 32'h00000001, 32'd1);
      for (int k = 8; k < 16; k++)
         step($sformatf("opsweep%0d", k), 4'(k), 32'h12345678, 32'h87654321);

      // Random, with some operand bias towards sign/edge values
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ra, rb;
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 5))
            0: ra = 32'h80000000 ^ {31'd0, ra[0]};
            1: rb = 32'h7FFFFFFF ^ {31'd0, rb[0]};
            2: rb = ra;
            default: ;
         endcase
         step($sformatf("rand%0d", i), 4'($urandom_range(0, 15)), ra, rb);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
